mc_main_control: RTL and testbench

//  Multicycle MIPS main control FSM; sits directly upstream of alu_control and drives its aluOp input
//  (00 add, 01 sub, 10 decode funct). Sequences fetch/decode/execute/memory/writeback for R-type,
//  lw, sw, beq, addi and j, emitting datapath mux selects and write enables per state.

---
 rtl/mc_main_control.sv | 177 +++++++++++++++++
 tb/tb_mc_main_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the alu_control aluOp field.
module mc_main_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    sFetch    = 4'd0,
    sDecode   = 4'd1,
    sMemAddr  = 4'd2,
    sMemRead  = 4'd3,
    sMemWb    = 4'd4,
    sMemWrite = 4'd5,
    sExecute  = 4'd6,
    sAluWb    = 4'd7,
    sBranch   = 4'd8,
    sJump     = 4'd9,
    sAddiExec = 4'd10,
    sAddiWb   = 4'd11
  } stateT;

  stateT curState;
  stateT nextState;
  logic  illegalQ;
  logic  decodeIllegal;

  // State register; illegal_op is a registered pulse raised out of DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState <= sFetch;
      illegalQ <= 1'b0;
    end else begin
      curState <= nextState;
      illegalQ <= decodeIllegal;
    end
  end

  // Next-state and per-state datapath controls; everything is held at 0 during reset.
  always_comb begin
    nextState     = curState;
    decodeIllegal = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    case (curState)
      sFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nextState = sDecode;
      end
      sDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nextState = sMemAddr;
          OP_RTYPE:     nextState = sExecute;
          OP_BEQ:       nextState = sBranch;
          OP_ADDI:      nextState = sAddiExec;
          OP_J:         nextState = sJump;
          default: begin
            nextState     = sFetch;
            decodeIllegal = 1'b1;
          end
        endcase
      end
      sMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nextState = (opcode == OP_LW) ? sMemRead : sMemWrite;
      end
      sMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nextState = sMemWb;
      end
      sMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nextState  = sFetch;
      end
      sMemWrite: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) nextState = sFetch;
      end
      sExecute: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nextState = sAluWb;
      end
      sAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nextState = sFetch;
      end
      sBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        nextState     = sFetch;
      end
      sJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        nextState = sFetch;
      end
      sAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nextState = sAddiWb;
      end
      sAddiWb: begin
        reg_write = 1'b1;
        nextState = sFetch;
      end
      default: nextState = sFetch;
    endcase

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
    end
  end

  assign state      = rst ? 4'd0 : 4'(curState);
  assign illegal_op = illegalQ & ~rst;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed scenarios plus random instruction streams,
// checked against an instruction-path reference model.
module tb_mc_main_control;

  typedef int intQ[$];

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: path of states an instruction walks, position on it, pending illegal pulse.
  intQ  pathQ;
  int   pos = 0;
  logic expIll = 1'b0;

  mc_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] ctlVec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  function automatic intQ pathOf(input logic [5:0] op);
    case (op)
      6'b000000: return '{0, 1, 6, 7};
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000100: return '{0, 1, 8};
      6'b001000: return '{0, 1, 10, 11};
      6'b000010: return '{0, 1, 9};
      default:   return '{0, 1};
    endcase
  endfunction

  // Control word expected in a given state, from the per-state output table.
  function automatic logic [15:0] expCtl(input int st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  function automatic int expState();
    if (pos == 0) return 0;
    if (pos == 1) return 1;
    return pathQ[pos];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    testsRun++;
    assert (got === want) else begin
      testsFailed++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic modelAdvance(input logic mr);
    logic nextIll;
    int   st;
    nextIll = 1'b0;
    if (pos == 0) begin
      if (mr) pos = 1;
    end else if (pos == 1) begin
      pathQ = pathOf(opcode);
      if (pathQ.size() == 2) begin
        pos = 0;
        nextIll = 1'b1;
      end else pos = 2;
    end else begin
      st = pathQ[pos];
      if (!((st == 3 || st == 5) && !mr)) begin
        pos++;
        if (pos == pathQ.size()) pos = 0;
      end
    end
    expIll = nextIll;
  endtask

  // One clock: apply mem_ready, check mid-cycle, then step model with the edge.
  task automatic runCycle(input logic mr);
    int es;
    mem_ready = mr;
    #3;
    es = expState();
    chk("state", 16'(state), 16'(es));
    chk("ctl", ctlVec, expCtl(es, mr));
    chk("illegal_op", 16'(illegal_op), 16'(expIll));
    chk("rd_wr_excl", 16'(mem_read & mem_write), 16'd0);
    modelAdvance(mr);
    @(posedge clk);
    #1;
  endtask

  task automatic dirStep(input logic mr, input int want);
    chk("dir_state", 16'(state), 16'(want));
    runCycle(mr);
  endtask

  task automatic checkAllZero(input string tag);
    chk(tag, {ctlVec[15:1], illegal_op}, 16'd0);
    chk({tag, "_state"}, 16'(state), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'b000000;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset_hold");
    rst = 1'b0;
    pos = 0;
    expIll = 1'b0;

    // R-type
    opcode = 6'b000000;
    dirStep(1, 0); dirStep(1, 1); dirStep(1, 6); dirStep(1, 7);
    // lw with two wait cycles in MEM_READ
    opcode = 6'b100011;
    dirStep(1, 0); dirStep(1, 1); dirStep(1, 2);
    dirStep(0, 3); dirStep(0, 3); dirStep(1, 3); dirStep(1, 4);
    // beq
    opcode = 6'b000100;
    dirStep(1, 0); dirStep(1, 1); dirStep(1, 8);
    // undecodable opcode, illegal pulse on the following FETCH
    opcode = 6'b111111;
    dirStep(1, 0); dirStep(1, 1);
    chk("illegal_pulse", 16'(illegal_op), 16'd1);
    // sw then j, first FETCH stalled
    opcode = 6'b101011;
    dirStep(0, 0);
    chk("no_irw_stall", 16'({ir_write, pc_write}), 16'd0);
    chk("illegal_one_cycle", 16'(illegal_op), 16'd0);
    dirStep(1, 0); dirStep(1, 1); dirStep(1, 2); dirStep(1, 5);
    opcode = 6'b000010;
    dirStep(1, 0); dirStep(1, 1);
    chk("j_pc_source", 16'(pc_source), 16'd2);
    dirStep(1, 9);
    // addi
    opcode = 6'b001000;
    dirStep(1, 0); dirStep(1, 1); dirStep(1, 10); dirStep(1, 11);

    // Async reset in the middle of a stalled MEM_READ
    opcode = 6'b100011;
    dirStep(1, 0); dirStep(1, 1); dirStep(1, 2);
    mem_ready = 1'b0;
    #2;
    chk("pre_reset_state", 16'(state), 16'd3);
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    #1;
    checkAllZero("reset_edge");
    rst = 1'b0;
    pos = 0;
    expIll = 1'b0;
    #1;
    chk("post_reset_fetch", {12'd0, state}, 16'd0);
    chk("post_reset_mem_read", 16'(mem_read), 16'd1);
    @(posedge clk);
    #1;

    // Random instruction stream
    for (int i = 0; i < 600; i++) begin
      if (pos == 0) begin
        case ($urandom_range(0, 7))
          0: opcode = 6'b000000;
          1: opcode = 6'b100011;
          2: opcode = 6'b101011;
          3: opcode = 6'b000100;
          4: opcode = 6'b001000;
          5: opcode = 6'b000010;
          default: opcode = 6'($urandom);
        endcase
      end
      runCycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
